// File: rtl/cnnip_pool.sv
// cnnip_pool: ReLU followed by 2x2/stride-2 max-pooling of the feature map.
// Reads four words per window, writes one pooled word per window.
module cnnip_pool #(
    parameter int FMAP_W = 28,
    parameter int FMAP_H = 28,
    parameter int ADDR_W = 12
) (
    input  logic              clk_a,
    input  logic              arstz_aq,
    input  logic              CMD_START,
    output logic              CMD_BUSY,
    output logic              CMD_DONE,
    output logic              CMD_DONE_VALID,
    output logic              feat_en,
    output logic [ADDR_W-1:0] feat_addr,
    input  logic [31:0]       feat_dout,
    output logic              pool_en,
    output logic              pool_we,
    output logic [ADDR_W-1:0] pool_addr,
    output logic [31:0]       pool_din
);

    if (FMAP_W % 2 != 0) begin : g_bad_w
        $error("cnnip_pool: FMAP_W must be even");
    end
    if (FMAP_H % 2 != 0) begin : g_bad_h
        $error("cnnip_pool: FMAP_H must be even");
    end

    localparam int CW = $clog2(FMAP_W > FMAP_H ? FMAP_W : FMAP_H);
    localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W / 2 - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(FMAP_H / 2 - 1);
    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ROW_B = ADDR_W'(FMAP_W * 4);
    localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(8);
    // From the last window of a row pair to the first of the next pair
    localparam logic [ADDR_W-1:0] STEP_R = ADDR_W'(FMAP_W * 4 + 8);

    typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

    state_t             state;
    logic [1:0]         rd_idx;
    logic [CW-1:0]      col;
    logic [CW-1:0]      row;
    logic [ADDR_W-1:0]  base;
    logic signed [31:0] acc;
    logic signed [31:0] din_s;
    logic signed [31:0] acc_max;
    logic [ADDR_W-1:0]  nxt_base;
    logic               last_col;
    logic               last_win;

    assign din_s    = feat_dout;
    assign acc_max  = (din_s > acc) ? din_s : acc;
    assign last_col = (col == COL_LAST);
    assign last_win = last_col && (row == ROW_LAST);
    assign nxt_base = last_col ? base + STEP_R : base + STEP_C;

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            state     <= IDLE;
            rd_idx    <= 2'd0;
            col       <= '0;
            row       <= '0;
            base      <= '0;
            feat_addr <= '0;
            pool_addr <= '0;
            acc       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (CMD_START) begin
                        state     <= RD;
                        rd_idx    <= 2'd0;
                        col       <= '0;
                        row       <= '0;
                        base      <= '0;
                        feat_addr <= '0;
                        pool_addr <= '0;
                    end
                end
                RD: begin
                    rd_idx <= rd_idx + 2'd1;
                    // acc starts at 0 so negative windows clamp (ReLU)
                    acc <= (rd_idx == 2'd0) ? 32'sd0 : acc_max;
                    case (rd_idx)
                        2'd0: feat_addr <= base + WORD;
                        2'd1: feat_addr <= base + ROW_B;
                        2'd2: feat_addr <= base + ROW_B + WORD;
                        default: state <= LAST;
                    endcase
                end
                LAST: begin
                    acc   <= acc_max;
                    state <= WR;
                end
                WR: begin
                    pool_addr <= pool_addr + WORD;
                    if (last_win) begin
                        state <= DONE;
                    end else begin
                        state     <= RD;
                        base      <= nxt_base;
                        feat_addr <= nxt_base;
                        col       <= last_col ? '0 : col + 1'b1;
                        row       <= last_col ? row + 1'b1 : row;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign CMD_BUSY       = (state != IDLE);
    assign CMD_DONE       = (state == DONE);
    assign CMD_DONE_VALID = (state == DONE);
    assign feat_en        = (state == RD);
    assign pool_en        = (state == WR);
    assign pool_we        = (state == WR);
    assign pool_din       = acc;

endmodule

// File: tb/tb_cnnip_pool.sv
// tb_cnnip_pool: random and directed maps, scoreboard of expected writes
// from a ReLU/max reference, plus handshake timing checks.
module tb_cnnip_pool;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int AW = 12;
    localparam int NW = (W / 2) * (H / 2);
    localparam int DONE_CYC = NW * 6 + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, done_v;
    logic          feat_en, pool_en, pool_we;
    logic [AW-1:0] feat_addr, pool_addr;
    logic [31:0]   feat_dout, pool_din;

    logic [31:0] fmem [0:1023];
    logic [31:0] pmem [0:1023];
    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          wr_count = 0;

    always #5 clk = ~clk;

    cnnip_pool #(.FMAP_W(W), .FMAP_H(H), .ADDR_W(AW)) dut (
        .clk_a(clk), .arstz_aq(rst_n), .CMD_START(start),
        .CMD_BUSY(busy), .CMD_DONE(done), .CMD_DONE_VALID(done_v),
        .feat_en(feat_en), .feat_addr(feat_addr), .feat_dout(feat_dout),
        .pool_en(pool_en), .pool_we(pool_we), .pool_addr(pool_addr),
        .pool_din(pool_din)
    );

    always @(posedge clk) begin
        if (feat_en) feat_dout <= fmem[feat_addr[AW-1:2]];
        if (pool_en && pool_we) pmem[pool_addr[AW-1:2]] <= pool_din;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (pool_en && pool_we) begin
            wr_count++;
            if (sbq.size() == 0) begin
                chk("unexpected write", {20'd0, pool_addr, pool_din}, 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("pool write", {20'd0, pool_addr, pool_din},
                    {20'd0, e.addr, e.data});
            end
        end
    end

    task automatic push_expected();
        for (int r = 0; r < H / 2; r++) begin
            for (int c = 0; c < W / 2; c++) begin
                int m = 0;
                for (int q = 0; q < 4; q++) begin
                    int v = fmem[(2 * r + q / 2) * W + 2 * c + q % 2];
                    if (v > m) m = v;
                end
                sbq.push_back('{addr: AW'((r * (W / 2) + c) * 4),
                                data: 32'(m)});
            end
        end
    endtask

    task automatic fill(input logic [31:0] v);
        for (int i = 0; i < W * H; i++) fmem[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < W * H; i++) begin
            if ($urandom_range(0, 3) == 0) fmem[i] = $urandom;
            else fmem[i] = 32'(int'($urandom_range(0, 2000)) - 1000);
        end
    endtask

    task automatic run_map(input string tag, input bit pulses,
                           input int rst_at, input bit b2b);
        int  done_at[$];
        int  busy_cnt = 0;
        int  runs = b2b ? 2 : 1;
        int  limit = b2b ? 2 * (DONE_CYC + 1) + 10 : DONE_CYC + 12;
        int  wr_snap;
        bit  aborted = 1'b0;
        sbq.delete();
        wr_count = 0;
        for (int i = 0; i < runs; i++) push_expected();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, " first read"}, {busy, feat_en}, 2'b11);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " outputs in reset"},
                    {busy, done, done_v, feat_en, pool_en, pool_we,
                     feat_addr, pool_addr, pool_din}, 64'd0);
                sbq.delete();
                aborted = 1'b1;
                break;
            end
            busy_cnt += int'(busy);
            if (done) begin
                done_at.push_back(k);
                chk({tag, " done_valid"}, done_v, 1'b1);
            end
            if (b2b) begin
                if (done_at.size() == 2) start = 1'b0;
            end else begin
                start = pulses && (k == 10 || k == 500 || k == 1176);
            end
        end
        if (aborted) begin
            wr_snap = wr_count;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (40) @(negedge clk);
            chk({tag, " writes after reset"}, wr_count, wr_snap);
            chk({tag, " idle after reset"}, busy, 1'b0);
            return;
        end
        chk({tag, " done pulses"}, done_at.size(), runs);
        if (done_at.size() > 0)
            chk({tag, " done cycle"}, done_at[0], DONE_CYC);
        // DONE returns to IDLE, which samples START again one cycle later
        if (b2b && done_at.size() > 1)
            chk({tag, " second done"}, done_at[1], 2 * DONE_CYC + 1);
        chk({tag, " busy cycles"}, busy_cnt, runs * DONE_CYC);
        chk({tag, " write count"}, wr_count, runs * NW);
        chk({tag, " scoreboard drained"}, sbq.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill(32'd0);
        repeat (3) @(negedge clk);
        chk("reset outputs",
            {busy, done, done_v, feat_en, pool_en, pool_we,
             feat_addr, pool_addr, pool_din}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < W * H; i++) fmem[i] = 32'(i - 400);
        run_map("ramp", 1'b0, 0, 1'b0);
        chk("ramp word 0", pmem[0], 32'd0);
        chk("ramp word 195", pmem[195], 32'd383);

        fill(32'h8000_0000);
        run_map("all min", 1'b0, 0, 1'b0);
        fill(32'h7FFF_FFFF);
        run_map("all max", 1'b0, 0, 1'b0);

        for (int q = 0; q < 4; q++) begin
            fill(32'hFFFF_FFFF);
            fmem[(6 + q / 2) * W + 14 + q % 2] = 32'd5;
            run_map("max pos", 1'b0, 0, 1'b0);
            chk("max pos word (3,7)", pmem[3 * (W / 2) + 7], 32'd5);
        end

        fill_random();
        run_map("start pulses", 1'b1, 0, 1'b0);

        fill_random();
        run_map("reset", 1'b0, 600, 1'b0);
        run_map("fresh", 1'b0, 0, 1'b0);

        fill_random();
        run_map("back to back", 1'b0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
